// File: rtl/fb_double_buffer.sv
// fb_double_buffer: two-bank byte frame buffer, writer fills the back bank, swap on read-address wrap.
// Optional FB_GAMMA_EN squares write data ((d*d)>>8) through an extra registered stage.
module fb_double_buffer #(
  parameter int DISPLAY_WIDTH  = 104,
  parameter int DISPLAY_HEIGHT = 32,
  parameter int BANK_SIZE      = 3328
) (
  input  logic        rd_clk,
  input  logic        reset,
  input  logic        wr_strobe,
  input  logic [7:0]  wr_x,
  input  logic [5:0]  wr_y,
  input  logic [7:0]  wr_data,
  input  logic        frame_done,
  input  logic [11:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        active_bank,
  output logic        swap_pending,
  output logic [7:0]  drop_count
);
  localparam int PLANE = DISPLAY_HEIGHT * (DISPLAY_WIDTH / 8);
  localparam int HALF  = DISPLAY_HEIGHT / 2;
  logic [7:0]  mem [2][BANK_SIZE];
  logic        in_range, wrap, swap;
  logic [11:0] wr_off, row;
  logic        active_q, active_d, pend_q, pend_d;
  logic [7:0]  drop_q, drop_d, rd_q;
  logic [11:0] prev_q;
  logic        wv_q, wb_q;
  logic [11:0] wa_q;
  logic [7:0]  wd_q;
  logic        mem_we, mem_b;
  logic [11:0] mem_a;
  logic [7:0]  mem_d;
  always_comb begin
    in_range = 32'(wr_x) < DISPLAY_WIDTH && 32'(wr_y) < DISPLAY_HEIGHT;
    row = 32'(wr_y) < HALF ? 12'(32'(wr_y) + HALF) : 12'(32'(wr_y) - HALF);
    wr_off = 12'(32'(wr_x[2:0]) * PLANE) + 12'(32'(wr_x[7:3]) * DISPLAY_HEIGHT) + row;
    wrap = rd_addr == 12'd0 && prev_q != 12'd0;
    swap = wrap && pend_q;
    active_d = active_q ^ swap;
    pend_d = frame_done | (pend_q & ~swap);
    drop_d = wr_strobe && !in_range && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      active_q <= 1'b0;
      pend_q   <= 1'b0;
      drop_q   <= 8'h00;
      prev_q   <= 12'd0;
      rd_q     <= 8'h00;
      wv_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      prev_q   <= rd_addr;
      rd_q     <= 32'(rd_addr) < BANK_SIZE ? mem[active_q][rd_addr] : 8'h00;
      wv_q     <= wr_strobe && in_range;
    end
  end
  // Bank is captured at the strobe so a swap before the memory write cannot redirect it.
  always_ff @(posedge rd_clk) begin
    wa_q <= wr_off;
    wd_q <= wr_data;
    wb_q <= ~active_q;
  end
`ifdef FB_GAMMA_EN
  logic        gv_q, gb_q;
  logic [11:0] ga_q;
  logic [7:0]  gd_q;
  always_ff @(posedge rd_clk) begin
    gv_q <= reset ? 1'b0 : wv_q;
    ga_q <= wa_q;
    gb_q <= wb_q;
    gd_q <= 8'((16'(wd_q) * 16'(wd_q)) >> 8);
  end
  assign mem_we = gv_q;
  assign mem_b  = gb_q;
  assign mem_a  = ga_q;
  assign mem_d  = gd_q;
`else
  assign mem_we = wv_q;
  assign mem_b  = wb_q;
  assign mem_a  = wa_q;
  assign mem_d  = wd_q;
`endif
  // Gating with reset cancels a write that is in flight when reset arrives.
  always_ff @(posedge rd_clk)
    if (mem_we && !reset) mem[mem_b][mem_a] <= mem_d;
  assign rd_data      = rd_q;
  assign active_bank  = active_q;
  assign swap_pending = pend_q;
  assign drop_count   = drop_q;
endmodule

// File: tb/tb_fb_double_buffer.sv
// tb_fb_double_buffer: table-driven write/readback checks plus hand sequences for swap, drop and reset corners.
module tb_fb_double_buffer;
`ifdef FB_GAMMA_EN
  localparam bit GAM = 1'b1;
`else
  localparam bit GAM = 1'b0;
`endif
  logic        rd_clk = 1'b0;
  logic        reset, wr_strobe, frame_done;
  logic [7:0]  wr_x, wr_data;
  logic [5:0]  wr_y;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data, drop_count;
  logic        active_bank, swap_pending;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0]  x;
    logic [5:0]  y;
    logic [7:0]  d;
    logic        ok;
    logic [11:0] off;
    logic [7:0]  e;
    logic [7:0]  dc;
  } vec_t;
  vec_t tv [11];
  fb_double_buffer dut (
    .rd_clk(rd_clk), .reset(reset), .wr_strobe(wr_strobe), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .frame_done(frame_done), .rd_addr(rd_addr), .rd_data(rd_data),
    .active_bank(active_bank), .swap_pending(swap_pending), .drop_count(drop_count)
  );
  always #5 rd_clk = ~rd_clk;
  function automatic logic [7:0] gam(input logic [7:0] d);
    logic [15:0] p;
    p = 16'(d) * 16'(d);
    return GAM ? p[15:8] : d;
  endfunction
  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic wr(input logic [7:0] x, input logic [5:0] y, input logic [7:0] d);
    wr_x = x; wr_y = y; wr_data = d; wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    tick();
    tick();
  endtask
  task automatic do_swap();
    frame_done = 1'b1;
    rd_addr = 12'd5;
    tick();
    frame_done = 1'b0;
    chk("pend_set", 12'(swap_pending), 12'd1);
    tick();
    rd_addr = 12'd0;
    tick();
  endtask
  initial begin
    tv[0]  = '{8'd9,   6'd3,  8'hA5, 1'b1, 12'd467,  gam(8'hA5), 8'd0};
    tv[1]  = '{8'd0,   6'd20, 8'h44, 1'b1, 12'd4,    gam(8'h44), 8'd0};
    tv[2]  = '{8'd103, 6'd31, 8'h5C, 1'b1, 12'd3311, gam(8'h5C), 8'd0};
    tv[3]  = '{8'd0,   6'd0,  8'h11, 1'b1, 12'd16,   gam(8'h11), 8'd0};
    tv[4]  = '{8'd8,   6'd16, 8'h22, 1'b1, 12'd32,   gam(8'h22), 8'd0};
    tv[5]  = '{8'd7,   6'd15, 8'h7E, 1'b1, 12'd2943, gam(8'h7E), 8'd0};
    tv[6]  = '{8'd0,   6'd16, 8'h5A, 1'b1, 12'd0,    gam(8'h5A), 8'd0};
    tv[7]  = '{8'd1,   6'd0,  8'h80, 1'b1, 12'd432,  GAM ? 8'h40 : 8'h80, 8'd0};
    tv[8]  = '{8'd104, 6'd0,  8'hE1, 1'b0, 12'd0,    8'h00, 8'd1};
    tv[9]  = '{8'd0,   6'd32, 8'hE2, 1'b0, 12'd0,    8'h00, 8'd2};
    tv[10] = '{8'd255, 6'd63, 8'hE3, 1'b0, 12'd0,    8'h00, 8'd3};
    reset = 1'b1; wr_strobe = 1'b0; frame_done = 1'b0;
    wr_x = 8'd0; wr_y = 6'd0; wr_data = 8'd0; rd_addr = 12'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_active", 12'(active_bank), 12'd0);
    chk("rst_pend", 12'(swap_pending), 12'd0);
    chk("rst_drop", 12'(drop_count), 12'd0);
    chk("rst_rdata", 12'(rd_data), 12'd0);
    for (int i = 0; i < 11; i++) begin
      wr(tv[i].x, tv[i].y, tv[i].d);
      chk($sformatf("drop_row%0d", i), 12'(drop_count), 12'(tv[i].dc));
    end
    do_swap();
    chk("swap1_active", 12'(active_bank), 12'd1);
    chk("swap1_pend", 12'(swap_pending), 12'd0);
    for (int i = 0; i < 11; i++)
      if (tv[i].ok) begin
        rd_addr = tv[i].off;
        tick();
        chk($sformatf("read_row%0d", i), 12'(rd_data), 12'(tv[i].e));
      end
    rd_addr = 12'd4000;
    tick();
    chk("read_oor", 12'(rd_data), 12'd0);
    wr(8'd0, 6'd16, 8'hC3);
    wr(8'd0, 6'd20, 8'h77);
    rd_addr = 12'd0;
    tick();
    chk("wrap_nopend", 12'(active_bank), 12'd1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    tick();
    tick();
    chk("held0_active", 12'(active_bank), 12'd1);
    chk("held0_pend", 12'(swap_pending), 12'd1);
    rd_addr = 12'd1;
    tick();
    rd_addr = 12'd0;
    tick();
    chk("swap2_active", 12'(active_bank), 12'd0);
    chk("swap2_pend", 12'(swap_pending), 12'd0);
    chk("swap2_oldbank", 12'(rd_data), 12'(gam(8'h5A)));
    tick();
    chk("swap2_newbank", 12'(rd_data), 12'(gam(8'hC3)));
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    rd_addr = 12'd1;
    tick();
    rd_addr = 12'd0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("coinc_active", 12'(active_bank), 12'd1);
    chk("coinc_pend", 12'(swap_pending), 12'd1);
    rd_addr = 12'd2;
    tick();
    rd_addr = 12'd0;
    tick();
    chk("coinc2_active", 12'(active_bank), 12'd0);
    chk("coinc2_pend", 12'(swap_pending), 12'd0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    rd_addr = 12'd3;
    tick();
    wr_x = 8'd0; wr_y = 6'd20; wr_data = 8'h33; wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    rd_addr = 12'd0;
    tick();
    chk("late_active", 12'(active_bank), 12'd1);
    rd_addr = 12'd3;
    tick();
    tick();
    rd_addr = 12'd4;
    tick();
    chk("late_write", 12'(rd_data), 12'(gam(8'h33)));
    wr_x = 8'd0; wr_y = 6'd20; wr_data = 8'hEE; wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_active", 12'(active_bank), 12'd0);
    chk("midrst_pend", 12'(swap_pending), 12'd0);
    chk("midrst_drop", 12'(drop_count), 12'd0);
    chk("midrst_rdata", 12'(rd_data), 12'd0);
    tick();
    tick();
    tick();
    chk("midrst_mem", 12'(rd_data), 12'(gam(8'h77)));
    wr_x = 8'd200; wr_y = 6'd0; wr_strobe = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    chk("drop_fe", 12'(drop_count), 12'h0FE);
    for (int i = 0; i < 46; i++) tick();
    wr_strobe = 1'b0;
    tick();
    chk("drop_sat", 12'(drop_count), 12'h0FF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_double_buffer.md
FB_DOUBLE_BUFFER -- requirements
Module: fb_double_buffer

Interface
REQ-001 The block SHALL take parameter DISPLAY_WIDTH, default 104, meaning panel columns.
REQ-002 The block SHALL take parameter DISPLAY_HEIGHT, default 32, meaning panel rows.
REQ-003 The block SHALL take parameter BANK_SIZE, default 3328, meaning bytes per bank (DISPLAY_WIDTH*DISPLAY_HEIGHT).
REQ-004 The block SHALL have port rd_clk, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port wr_strobe, input, 1, a one-cycle pixel-write request.
REQ-007 The block SHALL have port wr_x, input, 8, the pixel column.
REQ-008 The block SHALL have port wr_y, input, 6, the pixel row.
REQ-009 The block SHALL have port wr_data, input, 8, the grey level.
REQ-010 The block SHALL have port frame_done, input, 1, a one-cycle "back bank complete" pulse.
REQ-011 The block SHALL have port rd_addr, input, 12, the display-order read address from led_matrix.
REQ-012 The block SHALL have port rd_data, output, 8, the front-bank byte.
REQ-013 The block SHALL have port active_bank, output, 1, the index of the front (displayed) bank.
REQ-014 The block SHALL have port swap_pending, output, 1, high while a committed frame awaits swap.
REQ-015 The block SHALL have port drop_count, output, 8, a saturating count of out-of-bounds writes.

Function
REQ-016 The block SHALL hold two banks of BANK_SIZE bytes; writes go only to bank !active_bank and reads come only from bank active_bank.
REQ-017 A write SHALL be accepted when wr_strobe=1, wr_x<DISPLAY_WIDTH and wr_y<DISPLAY_HEIGHT.
REQ-018 An accepted write SHALL store to offset wr_x[2:0]*416 + wr_x[7:3]*32 + (wr_y<16 ? wr_y+16 : wr_y-16).
REQ-019 Accepted writes SHALL be pipelined: the address, data and target bank are registered at the strobe cycle, and memory is written on the next cycle.
REQ-020 The target bank SHALL be latched at the strobe cycle, so a swap occurring between strobe and memory write does not redirect that write.
REQ-021 Writes with an out-of-range coordinate SHALL NOT modify memory and SHALL increment drop_count, which saturates at 0xFF.
REQ-022 rd_data SHALL equal front_bank[rd_addr] registered one cycle after rd_addr is presented.
REQ-023 When rd_addr >= BANK_SIZE, rd_data SHALL be 0x00.
REQ-024 frame_done SHALL set swap_pending.
REQ-025 A frame wrap SHALL be defined as a cycle where rd_addr==0 and the previous cycle's rd_addr!=0.
REQ-026 On a frame wrap with swap_pending=1, the block SHALL toggle active_bank and clear swap_pending in that cycle.
REQ-027 If frame_done coincides with a swap cycle, the swap SHALL occur and swap_pending SHALL remain 1.
REQ-028 A frame_done while swap_pending=1 (with no swap) SHALL have no additional effect.
REQ-029 Writes while swap_pending=1 SHALL still be accepted into the back bank; avoiding tearing is the writer's responsibility.
REQ-030 A frame wrap with swap_pending=0 SHALL change nothing.
REQ-031 rd_data in the swap cycle SHALL come from the old front bank; the following read SHALL come from the new front bank.

Reset
REQ-032 Reset SHALL set active_bank=0, swap_pending=0, drop_count=0, rd_data=0x00, clear the write pipeline valid bit and set the previous-rd_addr register to 0.
REQ-033 Reset SHALL NOT clear memory contents, which initialise from fb-init.hex into both banks.
REQ-034 Reset asserted mid-write SHALL cancel the in-flight pipelined write.
REQ-035 Reset SHALL take priority over strobe, frame_done and swap in the same cycle.

Configuration
REQ-036 With macro FB_GAMMA_EN defined, wr_data SHALL pass through a 256-entry registered LUT (out=(in*in)>>8) before storage, so memory is written 2 cycles after strobe; bounds check, drop counting and the latched bank are unaffected.
REQ-037 Without FB_GAMMA_EN, wr_data SHALL be stored unmodified with 1-cycle write latency and no LUT.

Verification
REQ-038 The bench SHALL check: strobe x=9,y=3,data=0xA5, frame_done, then rd_addr stepped 5->0 -> swap; reading offset 1*416+1*32+19=467 returns 0xA5 one cycle later.
REQ-039 The bench SHALL check: strobe x=104,y=0 and x=0,y=32 -> memory unchanged, drop_count=2; after 300 bad strobes drop_count=0xFF.
REQ-040 The bench SHALL check: frame_done with rd_addr held at 0 -> no swap; rd_addr 1->0 -> active_bank toggles and swap_pending=0.
REQ-041 The bench SHALL check: frame_done in the same cycle as a wrap with pending=1 -> active_bank toggles and swap_pending stays 1.
REQ-042 The bench SHALL check: strobe x=0,y=20,data=0x33 on the cycle before a swap -> after the next swap, offset 4 reads 0x33 and the other bank is untouched.
REQ-043 The bench SHALL check: with FB_GAMMA_EN, write data 0x80 -> stored 0x40; reset asserted 1 cycle after strobe -> no memory write, active_bank=0.
